wb_result_writer: RTL

- Write-back end of the datapath: the consumer of ALU results and load data, opposite the operand-select muxes that feed the ALU.
- Selects the write-back source, applies load extension and sequences register-file writes.
- Single-register writes take one cycle. Register-list loads (LDM/POP) write one register per memory beat.
- Drives the register-file write port and the PC-load request.

---
 rtl/wb_result_writer_if.sv | 54 +++++
 rtl/wb_result_writer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_result_writer_if.sv
// ----------------------------------------------------------------------------
// wb_result_writer_if
//
// Bundles the write-back request handshake, the load-data return path and the
// register-file write port of wb_result_writer.
//
//   wb_valid      request present (master -> slave)
//   wb_ready      writer can accept a request (slave -> master)
//   wb_src_choose source select: ALU/MEM_WORD/UBYTE/SBYTE/UHALF/SHALF/LINK/LIST
//   wb_rd         destination register for non-LIST sources
//   wb_reg_list   register list for LIST (bits 0-7 = R0-R7, top bit = PC)
//   alu_result    ALU output
//   mem_rdata     load data, qualified by mem_valid
//   mem_valid     one memory beat this cycle
//   pc            current PC (LINK source)
//   rf_we         register-file write enable, one-cycle pulse per write
//   rf_waddr      register-file write address
//   rf_wdata      register-file write data
//   pc_load       this write targets R15, fetch must be redirected
//   busy          a request is in progress or its write is still pending
// ----------------------------------------------------------------------------
interface wb_result_writer_if #(
   parameter int DW     = 32,
   parameter int LIST_W = 9
);
   logic              wb_valid;
   logic              wb_ready;
   logic [2:0]        wb_src_choose;
   logic [3:0]        wb_rd;
   logic [LIST_W-1:0] wb_reg_list;
   logic [DW-1:0]     alu_result;
   logic [DW-1:0]     mem_rdata;
   logic              mem_valid;
   logic [DW-1:0]     pc;
   logic              rf_we;
   logic [3:0]        rf_waddr;
   logic [DW-1:0]     rf_wdata;
   logic              pc_load;
   logic              busy;

   // Writer side.
   modport slave (
      input  wb_valid, wb_src_choose, wb_rd, wb_reg_list,
      input  alu_result, mem_rdata, mem_valid, pc,
      output wb_ready, rf_we, rf_waddr, rf_wdata, pc_load, busy
   );

   // Requester / datapath side.
   modport master (
      output wb_valid, wb_src_choose, wb_rd, wb_reg_list,
      output alu_result, mem_rdata, mem_valid, pc,
      input  wb_ready, rf_we, rf_waddr, rf_wdata, pc_load, busy
   );
endinterface

// File: rtl/wb_result_writer.sv
// ----------------------------------------------------------------------------
// wb_result_writer
//
// Write-back end of the datapath. Accepts one write-back request at a time,
// selects its source (ALU result, extended load data, link address or a
// register-list load), and sequences the register-file writes. Single writes
// from ALU/LINK appear the cycle after acceptance; loads wait for a memory
// beat; register-list loads write one register per beat, lowest first.
//
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset
//   wb     wb_result_writer_if.slave (request, load data, register-file port)
// ----------------------------------------------------------------------------
module wb_result_writer #(
   parameter int DW     = 32,
   parameter int LIST_W = 9
) (
   input  logic                clk,
   input  logic                rst_n,
   wb_result_writer_if.slave   wb
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_MEM,
      ST_LIST
   } state_t;

   typedef enum logic [2:0] {
      SRC_ALU       = 3'd0,
      SRC_MEM_WORD  = 3'd1,
      SRC_MEM_UBYTE = 3'd2,
      SRC_MEM_SBYTE = 3'd3,
      SRC_MEM_UHALF = 3'd4,
      SRC_MEM_SHALF = 3'd5,
      SRC_LINK      = 3'd6,
      SRC_LIST      = 3'd7
   } src_t;

   localparam logic [3:0] PC_ADDR = 4'd15;

   // Code addresses are halfword/word aligned, so a value loaded into the PC
   // from a word, a list or the ALU has its bit 0 dropped.
   function automatic logic [DW-1:0] clr_lsb(input logic [DW-1:0] d);
      return {d[DW-1:1], 1'b0};
   endfunction

   state_t            r_state;
   state_t            w_next_state;

   src_t              r_src;
   logic [3:0]        r_rd;
   logic [LIST_W-1:0] r_list;

   logic              r_rf_we;
   logic              r_pc_load;
   logic [3:0]        r_rf_waddr;
   logic [DW-1:0]     r_rf_wdata;

   logic              w_accept;
   logic              w_we;
   logic [3:0]        w_waddr;
   logic [DW-1:0]     w_wdata;
   logic [DW-1:0]     w_mem_ext;
   logic [LIST_W-1:0] w_list_next;
   logic [LIST_W-1:0] w_list_onehot;
   logic [3:0]        w_list_addr;

   assign w_accept = wb.wb_valid && (r_state == ST_IDLE);

   // Load extension for the captured source.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves
      // it unassigned; an unassigned path would infer a latch.
      w_mem_ext = wb.mem_rdata;
      case (r_src)
         SRC_MEM_UBYTE: w_mem_ext = {{(DW-8){1'b0}}, wb.mem_rdata[7:0]};
         SRC_MEM_SBYTE: w_mem_ext = {{(DW-8){wb.mem_rdata[7]}}, wb.mem_rdata[7:0]};
         SRC_MEM_UHALF: w_mem_ext = {{(DW-16){1'b0}}, wb.mem_rdata[15:0]};
         SRC_MEM_SHALF: w_mem_ext = {{(DW-16){wb.mem_rdata[15]}}, wb.mem_rdata[15:0]};
         default:       w_mem_ext = wb.mem_rdata;
      endcase
   end

   // Lowest set bit of the remaining list (x & -x) and its register address;
   // the top list bit stands for the PC.
   assign w_list_onehot = r_list & (~r_list + LIST_W'(1));

   always_comb begin
      w_list_addr = 4'd0;
      for (int i = 0; i < LIST_W; i++) begin
         if (w_list_onehot[i]) begin
            w_list_addr = (i == LIST_W - 1) ? PC_ADDR : 4'(i);
         end
      end
   end

   // Next-state and write-port logic.
   always_comb begin
      w_next_state = r_state;
      w_we         = 1'b0;
      w_waddr      = r_rf_waddr;
      w_wdata      = r_rf_wdata;
      w_list_next  = r_list;

      unique case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               case (src_t'(wb.wb_src_choose))
                  SRC_ALU: begin
                     w_we    = 1'b1;
                     w_waddr = wb.wb_rd;
                     w_wdata = (wb.wb_rd == PC_ADDR) ? clr_lsb(wb.alu_result)
                                                     : wb.alu_result;
                  end
                  SRC_LINK: begin
                     // Link value carries the Thumb state bit.
                     w_we    = 1'b1;
                     w_waddr = wb.wb_rd;
                     w_wdata = wb.pc | DW'(1);
                  end
                  SRC_LIST: begin
                     // An empty list completes on acceptance with no write.
                     w_list_next = wb.wb_reg_list;
                     if (wb.wb_reg_list != '0) begin
                        w_next_state = ST_LIST;
                     end
                  end
                  default: begin
                     w_next_state = ST_WAIT_MEM;
                  end
               endcase
            end
         end

         ST_WAIT_MEM: begin
            if (wb.mem_valid) begin
               w_we         = 1'b1;
               w_waddr      = r_rd;
               w_wdata      = (r_src == SRC_MEM_WORD && r_rd == PC_ADDR)
                              ? clr_lsb(w_mem_ext) : w_mem_ext;
               w_next_state = ST_IDLE;
            end
         end

         ST_LIST: begin
            if (wb.mem_valid) begin
               w_we        = 1'b1;
               w_waddr     = w_list_addr;
               w_wdata     = (w_list_addr == PC_ADDR) ? clr_lsb(wb.mem_rdata)
                                                      : wb.mem_rdata;
               w_list_next = r_list & ~w_list_onehot;
               // Leave in the same cycle the last write is issued so a new
               // request can be taken while that write is on the port.
               if (w_list_next == '0) begin
                  w_next_state = ST_IDLE;
               end
            end
         end

         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Captured request and registered write port.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_src      <= SRC_ALU;
         r_rd       <= 4'd0;
         r_list     <= '0;
         r_rf_we    <= 1'b0;
         r_pc_load  <= 1'b0;
         r_rf_waddr <= 4'd0;
         r_rf_wdata <= '0;
      end else begin
         if (w_accept) begin
            r_src <= src_t'(wb.wb_src_choose);
            r_rd  <= wb.wb_rd;
         end
         r_list     <= w_list_next;
         r_rf_we    <= w_we;
         r_pc_load  <= w_we && (w_waddr == PC_ADDR);
         r_rf_waddr <= w_waddr;
         r_rf_wdata <= w_wdata;
      end
   end

   // The write strobes are masked while reset is asserted so a write that was
   // already registered cannot reach the register file in the reset cycle.
   assign wb.rf_we    = r_rf_we && rst_n;
   assign wb.pc_load  = r_pc_load && rst_n;
   assign wb.rf_waddr = r_rf_waddr;
   assign wb.rf_wdata = r_rf_wdata;
   assign wb.wb_ready = (r_state == ST_IDLE);
   assign wb.busy     = (r_state != ST_IDLE) || r_rf_we;

endmodule
